// File: rtl/data_check.sv
// data_check: receive-side frame checker.
// Hunts for a comma word (16'h017C), expects a header (16'h5555), checks
// PRBS_LENGTH PRBS words with a self-synchronising bit checker, then takes
// one tail word (16'hAAAA) and reports a per-frame result.
// Optional feature macro: DATA_CHECK_STATS_EN enables the frames_rx and
// frames_bad cumulative counters. When it is undefined, both ports are
// tied to zero.
module data_check #(
    parameter int PRBS_LENGTH = 8,
    parameter bit INV_PATTERN = 1'b1,
    parameter int POLY_LENGHT = 9,
    parameter int POLY_TAP    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [9:0]  frame_bit_err,
    output logic        in_frame,
    output logic [15:0] frames_rx,
    output logic [15:0] frames_bad
);

    localparam int CNT_W  = $clog2(PRBS_LENGTH);
    localparam int SEED_W = $clog2(POLY_LENGHT + 1);

    localparam logic [15:0] COMMA_WORD = 16'h017C;
    localparam logic [15:0] HEAD_WORD  = 16'h5555;
    localparam logic [15:0] TAIL_WORD  = 16'hAAAA;

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(PRBS_LENGTH - 1);
    localparam logic [SEED_W-1:0] SEED_FULL = SEED_W'(POLY_LENGHT);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_HEAD,
        ST_PRBS,
        ST_TAIL
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic [POLY_LENGHT-1:0] hist_q, hist_d;
    logic [SEED_W-1:0]      seed_cnt_q, seed_cnt_d;
    logic [9:0]             acc_q, acc_d;

    logic                   frame_done_q, frame_done_d;
    logic                   frame_ok_q, frame_ok_d;
    logic [9:0]             frame_bit_err_q, frame_bit_err_d;
    logic                   in_frame_q, in_frame_d;

    // Word-wide PRBS checker results
    logic [POLY_LENGHT-1:0] hist_next;
    logic [SEED_W-1:0]      seed_next;
    logic [4:0]             word_errs;
    logic                   rx_bit;
    logic                   exp_bit;
    logic [10:0]            acc_sum;
    logic [9:0]             acc_sat;

    // Walk the 16 bits of the incoming word in time order (bit 15 first);
    // bits are compared against the expected value only once the history
    // has been seeded with POLY_LENGHT received bits of this frame.
    always_comb begin
        hist_next = hist_q;
        seed_next = seed_cnt_q;
        word_errs = '0;
        rx_bit    = 1'b0;
        exp_bit   = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            rx_bit  = data_in[i];
            exp_bit = hist_next[POLY_TAP-1] ^ hist_next[POLY_LENGHT-1] ^ INV_PATTERN;
            if (seed_next == SEED_FULL) begin
                if (rx_bit != exp_bit) begin
                    word_errs = word_errs + 5'd1;
                end
            end else begin
                seed_next = seed_next + SEED_W'(1);
            end
            hist_next = {hist_next[POLY_LENGHT-2:0], rx_bit};
        end
        acc_sum = {1'b0, acc_q} + 11'(word_errs);
        acc_sat = (acc_sum > 11'd1023) ? 10'h3FF : acc_sum[9:0];
    end

    // Frame FSM next-state and registered-output computation; nothing
    // moves on cycles without data_valid, except that frame_done drops.
    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        hist_d          = hist_q;
        seed_cnt_d      = seed_cnt_q;
        acc_d           = acc_q;
        frame_done_d    = 1'b0;
        frame_ok_d      = frame_ok_q;
        frame_bit_err_d = frame_bit_err_q;
        if (data_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (data_in == COMMA_WORD) begin
                        state_d = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (data_in == HEAD_WORD) begin
                        state_d    = ST_PRBS;
                        word_cnt_d = '0;
                        acc_d      = '0;
                        hist_d     = '0;
                        seed_cnt_d = '0;
                    end else if (data_in != COMMA_WORD) begin
                        state_d = ST_HUNT;
                    end
                end
                ST_PRBS: begin
                    hist_d     = hist_next;
                    seed_cnt_d = seed_next;
                    acc_d      = acc_sat;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    state_d         = ST_HUNT;
                    frame_done_d    = 1'b1;
                    frame_ok_d      = (data_in == TAIL_WORD) && (acc_q == 10'd0);
                    frame_bit_err_d = acc_q;
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
        in_frame_d = (state_d != ST_HUNT);
    end

    // State, checker history and frame results register; reset wins over data_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_HUNT;
            word_cnt_q      <= '0;
            hist_q          <= '0;
            seed_cnt_q      <= '0;
            acc_q           <= '0;
            frame_done_q    <= 1'b0;
            frame_ok_q      <= 1'b0;
            frame_bit_err_q <= '0;
            in_frame_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            hist_q          <= hist_d;
            seed_cnt_q      <= seed_cnt_d;
            acc_q           <= acc_d;
            frame_done_q    <= frame_done_d;
            frame_ok_q      <= frame_ok_d;
            frame_bit_err_q <= frame_bit_err_d;
            in_frame_q      <= in_frame_d;
        end
    end

    assign frame_done    = frame_done_q;
    assign frame_ok      = frame_ok_q;
    assign frame_bit_err = frame_bit_err_q;
    assign in_frame      = in_frame_q;

`ifdef DATA_CHECK_STATS_EN
    logic [15:0] frames_rx_q, frames_rx_d;
    logic [15:0] frames_bad_q, frames_bad_d;

    // Saturating frame counters, stepped on the edge that raises frame_done.
    always_comb begin
        frames_rx_d  = frames_rx_q;
        frames_bad_d = frames_bad_q;
        if (frame_done_d) begin
            if (frames_rx_q != 16'hFFFF) begin
                frames_rx_d = frames_rx_q + 16'd1;
            end
            if (!frame_ok_d && (frames_bad_q != 16'hFFFF)) begin
                frames_bad_d = frames_bad_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_rx_q  <= '0;
            frames_bad_q <= '0;
        end else begin
            frames_rx_q  <= frames_rx_d;
            frames_bad_q <= frames_bad_d;
        end
    end

    assign frames_rx  = frames_rx_q;
    assign frames_bad = frames_bad_q;
`else
    assign frames_rx  = '0;
    assign frames_bad = '0;
`endif

endmodule

// File: tb/tb_data_check.sv
// tb_data_check: directed table of cycle-by-cycle vectors followed by a
// randomized stream of frames checked against a bit-level reference.
module tb_data_check;

    localparam int PLEN   = 8;
    localparam int NBITS  = PLEN * 16;
    localparam bit INV    = 1'b1;
    localparam int PL     = 9;
    localparam int PT     = 5;
`ifdef DATA_CHECK_STATS_EN
    localparam bit STATS  = 1'b1;
`else
    localparam bit STATS  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        frame_done;
    logic        frame_ok;
    logic [9:0]  frame_bit_err;
    logic        in_frame;
    logic [15:0] frames_rx;
    logic [15:0] frames_bad;

    data_check #(
        .PRBS_LENGTH(PLEN),
        .INV_PATTERN(INV),
        .POLY_LENGHT(PL),
        .POLY_TAP(PT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_valid(data_valid),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .frame_bit_err(frame_bit_err),
        .in_frame(in_frame),
        .frames_rx(frames_rx),
        .frames_bad(frames_bad)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int cyc = 0;
    // Cycle counter used to time frame_done against the tail sample
    always @(posedge clk) cyc++;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic        rst;
        logic        done;
        logic        ok;
        logic [9:0]  err;
        logic        inf;
        logic [15:0] rx;
        logic [15:0] bad;
    } vec_t;

    vec_t tbl[$];

    logic        h_ok;
    logic [9:0]  h_err;
    logic [15:0] h_rx;
    logic [15:0] h_bad;

    bit          frame_bits[NBITS];
    logic [15:0] frame_words[PLEN];

    typedef struct {
        int         cyc;
        logic       ok;
        logic [9:0] err;
    } exp_t;

    exp_t expq[$];
    bit   mon_on = 1'b0;
    int   total_frames = 0;
    int   bad_frames = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n      = v.rst;
        data_in    = v.data;
        data_valid = v.valid;
    endtask

    // Clean PRBS frame in time order from a seed, stream inverted when INV is set
    task automatic buildPrbs(input logic [PL-1:0] seed);
        bit p[NBITS];
        for (int n = 0; n < NBITS; n++) begin
            if (n < PL) p[n] = seed[n];
            else        p[n] = p[n-PT] ^ p[n-PL];
            frame_bits[n] = p[n] ^ INV;
        end
    endtask

    task automatic packWords();
        for (int w = 0; w < PLEN; w++)
            for (int i = 0; i < 16; i++)
                frame_words[w][15-i] = frame_bits[16*w + i];
    endtask

    // Count bits after the seeding window that break the recurrence
    function automatic int refErrors();
        int cnt = 0;
        for (int n = PL; n < NBITS; n++)
            if (frame_bits[n] != (INV ^ frame_bits[n-PT] ^ frame_bits[n-PL])) cnt++;
        return (cnt > 1023) ? 1023 : cnt;
    endfunction

    task automatic addRow(input logic [15:0] d, input logic v, input logic r,
                          input logic done, input logic ok, input logic [9:0] err,
                          input logic inf);
        vec_t row;
        if (!r) begin
            h_ok = 1'b0; h_err = '0; h_rx = '0; h_bad = '0;
        end else if (done) begin
            h_ok  = ok;
            h_err = err;
            if (STATS) begin
                h_rx = h_rx + 16'd1;
                if (!ok) h_bad = h_bad + 16'd1;
            end
        end
        row = '{d, v, r, done, h_ok, h_err, inf, h_rx, h_bad};
        tbl.push_back(row);
    endtask

    task automatic addWord(input logic [15:0] d, input logic inf, input logic done,
                           input logic ok, input logic [9:0] err, input bit gaps);
        addRow(d, 1'b1, 1'b1, done, ok, err, inf);
        if (gaps) addRow(16'h017C, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, inf);
    endtask

    task automatic addFrame(input int flip_idx, input logic [15:0] tail, input bit gaps,
                            input logic ok, input logic [9:0] err);
        buildPrbs(9'h0A5);
        if (flip_idx >= 0) frame_bits[flip_idx] = ~frame_bits[flip_idx];
        packWords();
        addWord(16'h017C, 1'b1, 1'b0, 1'b0, 10'd0, gaps);
        addWord(16'h5555, 1'b1, 1'b0, 1'b0, 10'd0, gaps);
        for (int w = 0; w < PLEN; w++) addWord(frame_words[w], 1'b1, 1'b0, 1'b0, 10'd0, gaps);
        addWord(tail, 1'b0, 1'b1, ok, err, gaps);
        addRow(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    endtask

    function automatic logic [15:0] randJunk();
        logic [15:0] w;
        do w = 16'($urandom); while (w == 16'h017C);
        return w;
    endfunction

    task automatic sendWord(input logic [15:0] d, input bit is_tail,
                            input logic ok, input logic [9:0] err);
        exp_t e;
        while ($urandom_range(0, 3) == 0) begin
            data_in    = 16'($urandom);
            data_valid = 1'b0;
            @(negedge clk);
        end
        data_in    = d;
        data_valid = 1'b1;
        if (is_tail) begin
            e = '{cyc + 1, ok, err};
            expq.push_back(e);
        end
        @(negedge clk);
    endtask

    // Frame-result monitor for the randomized phase
    always @(negedge clk) begin
        if (mon_on) begin
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                checkOutput("rand frame_done", 16'(frame_done), 16'd1);
                checkOutput("rand frame_ok", 16'(frame_ok), 16'(expq[0].ok));
                checkOutput("rand frame_bit_err", 16'(frame_bit_err), 16'(expq[0].err));
                void'(expq.pop_front());
            end else if (frame_done) begin
                checkOutput("rand spurious frame_done", 16'(frame_done), 16'd0);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] x;
        logic [15:0] tail;
        logic        ok;
        int          err;
        int          choice;

        h_ok = 1'b0; h_err = '0; h_rx = '0; h_bad = '0;

        // Reset and idle
        addRow(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        addRow(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        // Clean frame
        addFrame(-1, 16'hAAAA, 1'b0, 1'b1, 10'd0);
        // Bit 0 of PRBS word 3 flipped: the bit itself plus two downstream checks
        addFrame(3*16 + 15, 16'hAAAA, 1'b0, 1'b0, 10'd3);
        // Bad tail with clean PRBS
        addFrame(-1, 16'hAAAB, 1'b0, 1'b0, 10'd0);
        // Aborted header, then clean frame
        addRow(16'h017C, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1);
        addRow(16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        addFrame(-1, 16'hAAAA, 1'b0, 1'b1, 10'd0);
        // Clean frame with data_valid low every other cycle
        addFrame(-1, 16'hAAAA, 1'b1, 1'b1, 10'd0);
        // Reset during PRBS word 4, then clean frame
        addWord(16'h017C, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        addWord(16'h5555, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        for (int w = 0; w < 4; w++) addWord(frame_words[w], 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        addRow(16'h017C, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        addFrame(-1, 16'hAAAA, 1'b0, 1'b1, 10'd0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d frame_done", i), 16'(frame_done), 16'(tbl[i].done));
            checkOutput($sformatf("row%0d in_frame", i), 16'(in_frame), 16'(tbl[i].inf));
            checkOutput($sformatf("row%0d frame_ok", i), 16'(frame_ok), 16'(tbl[i].ok));
            checkOutput($sformatf("row%0d frame_bit_err", i), 16'(frame_bit_err), 16'(tbl[i].err));
            checkOutput($sformatf("row%0d frames_rx", i), frames_rx, tbl[i].rx);
            checkOutput($sformatf("row%0d frames_bad", i), frames_bad, tbl[i].bad);
        end

        // Randomized stream
        rst_n = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;
        for (int it = 0; it < 60; it++) begin
            choice = $urandom_range(0, 9);
            if (choice < 2) begin
                repeat ($urandom_range(1, 3)) sendWord(randJunk(), 1'b0, 1'b0, 10'd0);
            end else if (choice == 2) begin
                sendWord(16'h017C, 1'b0, 1'b0, 10'd0);
                do x = 16'($urandom); while (x == 16'h017C || x == 16'h5555);
                sendWord(x, 1'b0, 1'b0, 10'd0);
            end else begin
                buildPrbs(PL'($urandom));
                if ($urandom_range(0, 1) == 1)
                    repeat ($urandom_range(1, 4)) begin
                        int k;
                        k = $urandom_range(0, NBITS - 1);
                        frame_bits[k] = ~frame_bits[k];
                    end
                packWords();
                err  = refErrors();
                tail = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hAAAA;
                ok   = (tail == 16'hAAAA) && (err == 0);
                sendWord(16'h017C, 1'b0, 1'b0, 10'd0);
                repeat ($urandom_range(0, 2)) sendWord(16'h017C, 1'b0, 1'b0, 10'd0);
                sendWord(16'h5555, 1'b0, 1'b0, 10'd0);
                for (int w = 0; w < PLEN; w++) sendWord(frame_words[w], 1'b0, 1'b0, 10'd0);
                sendWord(tail, 1'b1, ok, 10'(err));
                total_frames++;
                if (!ok) bad_frames++;
            end
        end
        data_valid = 1'b0;
        repeat (5) @(negedge clk);
        mon_on = 1'b0;
        checkOutput("rand pending frames", 16'(expq.size()), 16'd0);
        checkOutput("rand frames_rx", frames_rx, STATS ? 16'(total_frames) : 16'd0);
        checkOutput("rand frames_bad", frames_bad, STATS ? 16'(bad_frames) : 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
